serial_parity_rx: RTL and testbench
===================================

Name: serial_parity_rx

Overview:
- Receiving end of the team's serial parity link: deserialises one frame per (DATA_W+3) clocks, one bit per clock, and checks parity with an XOR accumulator.
- Frame format, LSB-first: start bit (0), DATA_W data bits, parity bit, stop bit (1).
- Delivers the parallel word with parity-error and framing-error flags.
- Sits after the line synchroniser and feeds the downstream word consumer.

Parameters:
- DATA_W, 8, number of data bits per frame; legal range 1..16.
- PARITY_ODD, 0, parity sense: 0 = even (XOR of data and parity bit must be 0), 1 = odd (XOR must be 1).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial line, idle high, already synchronised to clk.
- data_out  output  DATA_W  last received data word, LSB = first data bit received.
- valid  output  1  one-cycle pulse: data_out, par_err and frame_err are new.
- par_err  output  1  parity mismatch on the last frame.
- frame_err  output  1  stop bit of the last frame sampled as 0.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset is synchronous and active-high. The clock is clk and the reset is rst, with a single clock domain.
- While rst=1 at a clock edge, all of the following hold after that edge:
  - state = IDLE
  - data_out = 0, valid = 0, par_err = 0, frame_err = 0, busy = 0
  - shift register, bit counter and parity accumulator = 0
- rst overrides everything. Reset mid-frame discards the partial frame and no valid is produced for it.
- State machine with states IDLE, DATA, PARITY, STOP:
  - IDLE: if sin=0, go to DATA, clear the bit counter, and preset the parity accumulator to PARITY_ODD. Otherwise stay in IDLE.
  - DATA: shift sin into the MSB of the shift register (right shift, so the first bit ends at the LSB), XOR sin into the accumulator, and increment the counter. After the DATA_W-th bit, go to PARITY.
  - PARITY: XOR sin into the accumulator, then go to STOP.
  - STOP: sample sin, then go to IDLE.
- Output registers load on the edge that leaves STOP:
  - data_out <= shift register
  - par_err <= final accumulator (nonzero means mismatch)
  - frame_err <= ~sin
  - valid <= 1
- valid is high for exactly the one cycle after that edge. data_out, par_err and frame_err hold until the next valid.
- Latency: start bit sampled in cycle 0, data in cycles 1..DATA_W, parity in DATA_W+1, stop in DATA_W+2; valid is high in cycle DATA_W+3.
- Back-to-back frames: the FSM is in IDLE during the valid cycle, and a start bit sampled in that same cycle is accepted. Sustained throughput is one frame per DATA_W+3 clocks.
- A frame with a framing error still delivers data_out and par_err. No resynchronisation beyond returning to IDLE.
- A 0 on sin is only treated as a start bit when in IDLE. No glitch or false-start filtering: the line is pre-synchronised.
- Bit counter width is clog2(DATA_W+1). The counter never wraps within a frame.
- Idle line (sin constantly 1): the FSM stays in IDLE, busy = 0, and no valid is produced.

Decomposition:
- Shared package serial_link_pkg holds:
  - state enum (IDLE, DATA, PARITY, STOP)
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1
  - a frame-length function DATA_W+3, shared with the matching transmitter
- One sub-module, parity_accumulator (clk, rst, clear, preset, en, d, par): a one-bit XOR accumulator.
  - Reused unchanged by the transmitter to generate the parity bit.
- The FSM, counter, shift register and output registers stay in serial_parity_rx.

Test Plan:
- Frame 0xA5, even parity bit 0, stop 1 (DATA_W=8, PARITY_ODD=0) -> valid in cycle 11, data_out=0xA5, par_err=0, frame_err=0, busy high in cycles 1..10 only.
- Frame 0xA5 with parity bit 1 -> data_out=0xA5, par_err=1, frame_err=0.
- Frame 0x3C, parity 0, stop bit 0 -> data_out=0x3C, par_err=0, frame_err=1, then the FSM returns to IDLE.
- Back-to-back frames 0x01 (parity 1) then 0xFF (parity 0), with the second start bit in the first valid cycle -> two valid pulses 11 cycles apart, data_out=0x01 then 0xFF, par_err=0 both times.
- rst pulsed in cycle 5 of a 0x5A frame, then a full 0x0F frame -> no valid for 0x5A and all outputs 0 after the reset edge; then data_out=0x0F, par_err=0.
- PARITY_ODD=1 variant: frame 0x07 with parity 0 gives par_err=0; frame 0x07 with parity 1 gives par_err=1. Idle line for 50 cycles gives no valid and busy=0.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial parity link.
// Used by both the receiver and the matching transmitter.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Clocks per frame: start, data bits, parity, stop.
  function automatic int frame_len(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/parity_accumulator.sv
// One-bit XOR accumulator with synchronous preset.
// Shared by the link receiver and transmitter.
module parity_accumulator (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic preset,
  input  logic en,
  input  logic d,
  output logic par
);

  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (clear) begin
      par <= preset;
    end else if (en) begin
      par <= par ^ d;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial parity link receiver: start, LSB-first data,
// parity, stop; one frame per DATA_W+3 clocks.
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              par_err,
  output logic              frame_err,
  output logic              busy
);

  import serial_link_pkg::*;

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   sr;
  logic [DATA_W-1:0]   sr_next;
  logic                acc;
  logic                acc_clear;
  logic                acc_en;

  // Right shift so the first data bit lands in the LSB.
  if (DATA_W == 1) begin : g_sr1
    assign sr_next = sin;
  end else begin : g_srn
    assign sr_next = {sin, sr[DATA_W-1:1]};
  end

  assign acc_clear = (state == IDLE) && (sin == START_BIT);
  assign acc_en    = (state == DATA) || (state == PARITY);
  assign busy      = (state != IDLE);

  parity_accumulator u_par (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .preset (PARITY_ODD),
    .en     (acc_en),
    .d      (sin),
    .par    (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sin == START_BIT) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          sr  <= sr_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= PARITY;
          end
        end
        PARITY: begin
          state <= STOP;
        end
        STOP: begin
          data_out  <= sr;
          par_err   <= acc;
          frame_err <= (sin != STOP_BIT);
          valid     <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx, even and odd
// parity instances sharing one serial line.
module tb_serial_parity_rx;

  logic       clk;
  logic       rst;
  logic       sin;
  logic [7:0] data_e;
  logic       valid_e;
  logic       perr_e;
  logic       ferr_e;
  logic       busy_e;
  logic [7:0] data_o;
  logic       valid_o;
  logic       perr_o;
  logic       ferr_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_e (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .data_out  (data_e),
    .valid     (valid_e),
    .par_err   (perr_e),
    .frame_err (ferr_e),
    .busy      (busy_e)
  );

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_o (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .data_out  (data_o),
    .valid     (valid_o),
    .par_err   (perr_o),
    .frame_err (ferr_o),
    .busy      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives cycles 0..10 of a frame; returns at the start of cycle 11
  // without touching sin, so the caller picks idle or a new start bit.
  task automatic send(input logic [7:0] d, input logic p,
                      input logic s, input bit chk_bv);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i <= 10; i++) begin
      sin = bits[i];
      if (chk_bv) begin
        chk("busy_in_frame", 16'(busy_e), 16'(i != 0));
        if (i != 0) chk("valid_in_frame", 16'(valid_e), 16'd0);
      end
      step();
    end
  endtask

  task automatic chk_e(input string tag, input logic [7:0] d,
                       input logic pe, input logic fe);
    chk({tag, "_valid"}, 16'(valid_e), 16'd1);
    chk({tag, "_data"}, 16'(data_e), 16'(d));
    chk({tag, "_perr"}, 16'(perr_e), 16'(pe));
    chk({tag, "_ferr"}, 16'(ferr_e), 16'(fe));
    chk({tag, "_busy"}, 16'(busy_e), 16'd0);
  endtask

  initial begin
    logic [10:0] f5a;
    bit seen;
    rst = 1'b1;
    sin = 1'b1;
    step();
    step();
    chk("rst_data", 16'(data_e), 16'd0);
    chk("rst_valid", 16'(valid_e), 16'd0);
    chk("rst_perr", 16'(perr_e), 16'd0);
    chk("rst_ferr", 16'(ferr_e), 16'd0);
    chk("rst_busy", 16'(busy_e), 16'd0);
    rst = 1'b0;
    step();

    send(8'hA5, 1'b0, 1'b1, 1'b1);
    sin = 1'b1;
    chk_e("a5_ok", 8'hA5, 1'b0, 1'b0);
    step();
    chk("a5_valid_drop", 16'(valid_e), 16'd0);
    chk("a5_hold_data", 16'(data_e), 16'h00A5);

    send(8'hA5, 1'b1, 1'b1, 1'b1);
    sin = 1'b1;
    chk_e("a5_perr", 8'hA5, 1'b1, 1'b0);
    step();

    send(8'h3C, 1'b0, 1'b0, 1'b1);
    sin = 1'b1;
    chk_e("3c_ferr", 8'h3C, 1'b0, 1'b1);
    step();
    chk("3c_idle_busy", 16'(busy_e), 16'd0);
    chk("3c_idle_valid", 16'(valid_e), 16'd0);
    step();

    send(8'h01, 1'b1, 1'b1, 1'b1);
    chk_e("b2b_first", 8'h01, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b1, 1'b1);
    sin = 1'b1;
    chk_e("b2b_second", 8'hFF, 1'b0, 1'b0);
    step();

    f5a = {1'b1, 1'b0, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      sin = f5a[i];
      step();
    end
    rst = 1'b1;
    sin = f5a[5];
    step();
    chk("midrst_data", 16'(data_e), 16'd0);
    chk("midrst_valid", 16'(valid_e), 16'd0);
    chk("midrst_busy", 16'(busy_e), 16'd0);
    chk("midrst_perr", 16'(perr_e), 16'd0);
    rst = 1'b0;
    sin = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid_e === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_valid", 16'(seen), 16'd0);

    send(8'h0F, 1'b0, 1'b1, 1'b1);
    sin = 1'b1;
    chk_e("0f_after_rst", 8'h0F, 1'b0, 1'b0);
    step();

    send(8'h07, 1'b0, 1'b1, 1'b0);
    sin = 1'b1;
    chk("odd07_p0_valid", 16'(valid_o), 16'd1);
    chk("odd07_p0_data", 16'(data_o), 16'h0007);
    chk("odd07_p0_perr", 16'(perr_o), 16'd0);
    chk("even07_p0_perr", 16'(perr_e), 16'd1);
    step();

    send(8'h07, 1'b1, 1'b1, 1'b0);
    sin = 1'b1;
    chk("odd07_p1_valid", 16'(valid_o), 16'd1);
    chk("odd07_p1_perr", 16'(perr_o), 16'd1);
    chk("odd07_p1_ferr", 16'(ferr_o), 16'd0);
    step();

    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_odd", 16'({valid_o, busy_o}), 16'd0);
    end
    chk("idle_hold_perr", 16'(perr_o), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
